// File: rtl/move_hilo_unit.sv
// EX-stage move unit: MOVN/MOVZ, MFHI/MFLO, MTHI/MTLO and WHILO over NACC HI/LO pairs.
// Writes retire through a COMMIT_LAT-deep pending pipeline; reads forward youngest-first.
module move_hilo_unit #(
   parameter int DW         = 32,
   parameter int NACC       = 4,
   parameter int ACC_W      = 2,
   parameter int COMMIT_LAT = 2
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                in_valid_i,
   input  logic [2:0]          op_i,
   input  logic [ACC_W-1:0]    acc_i,
   input  logic [DW-1:0]       opdata1_i,
   input  logic [DW-1:0]       opdata2_i,
   input  logic [2*DW-1:0]     hilo_wdata_i,
   input  logic                stall_i,
   input  logic                flush_i,
   output logic                out_valid_o,
   output logic                out_we_o,
   output logic [DW-1:0]       out_data_o,
   output logic [2*DW-1:0]     arch_hilo_o
);

   typedef enum logic [2:0] {
      OP_NOP   = 3'd0,
      OP_MOVN  = 3'd1,
      OP_MOVZ  = 3'd2,
      OP_MFHI  = 3'd3,
      OP_MFLO  = 3'd4,
      OP_MTHI  = 3'd5,
      OP_MTLO  = 3'd6,
      OP_WHILO = 3'd7
   } op_e;

   typedef struct packed {
      logic             valid;
      logic [ACC_W-1:0] acc;
      logic             hi_en;
      logic             lo_en;
      logic [DW-1:0]    hi;
      logic [DW-1:0]    lo;
   } stage_t;

   logic [DW-1:0] hi_r    [NACC];
   logic [DW-1:0] lo_r    [NACC];
   stage_t        stage_r [COMMIT_LAT];

   logic          accept_s;
   logic          acc_ok_s;
   logic [DW-1:0] arch_hi_s;
   logic [DW-1:0] arch_lo_s;
   logic [DW-1:0] fwd_hi_s;
   logic [DW-1:0] fwd_lo_s;
   logic          res_we_s;
   logic [DW-1:0] res_data_s;
   stage_t        new_stage_s;

   assign accept_s    = in_valid_i & ~stall_i & ~flush_i;
   assign acc_ok_s    = (32'(acc_i) < NACC);
   assign arch_hilo_o = {hi_r[0], lo_r[0]};

   // Forwarded HI/LO read: architectural value, overridden oldest-to-youngest by matching pending halves
   always_comb begin
      arch_hi_s = '0;
      arch_lo_s = '0;
      for (int a = 0; a < NACC; a++) begin
         arch_hi_s = (acc_ok_s && (acc_i == ACC_W'(a))) ? hi_r[a] : arch_hi_s;
         arch_lo_s = (acc_ok_s && (acc_i == ACC_W'(a))) ? lo_r[a] : arch_lo_s;
      end
      fwd_hi_s = arch_hi_s;
      fwd_lo_s = arch_lo_s;
      for (int i = COMMIT_LAT - 1; i >= 0; i--) begin
         fwd_hi_s = (stage_r[i].valid && (stage_r[i].acc == acc_i) && stage_r[i].hi_en)
                    ? stage_r[i].hi : fwd_hi_s;
         fwd_lo_s = (stage_r[i].valid && (stage_r[i].acc == acc_i) && stage_r[i].lo_en)
                    ? stage_r[i].lo : fwd_lo_s;
      end
   end

   // Result decode and pending-write formation for the issuing op
   always_comb begin
      res_we_s    = 1'b0;
      res_data_s  = '0;
      new_stage_s = '0;
      new_stage_s.acc = acc_i;
      case (op_i)
         OP_MOVN: begin
            res_we_s   = |opdata2_i;
            res_data_s = opdata1_i;
         end
         OP_MOVZ: begin
            res_we_s   = ~|opdata2_i;
            res_data_s = opdata1_i;
         end
         OP_MFHI: begin
            res_we_s   = 1'b1;
            res_data_s = fwd_hi_s;
         end
         OP_MFLO: begin
            res_we_s   = 1'b1;
            res_data_s = fwd_lo_s;
         end
         OP_MTHI: begin
            new_stage_s.hi_en = 1'b1;
            new_stage_s.hi    = opdata1_i;
         end
         OP_MTLO: begin
            new_stage_s.lo_en = 1'b1;
            new_stage_s.lo    = opdata1_i;
         end
         OP_WHILO: begin
            new_stage_s.hi_en = 1'b1;
            new_stage_s.lo_en = 1'b1;
            new_stage_s.hi    = hilo_wdata_i[2*DW-1:DW];
            new_stage_s.lo    = hilo_wdata_i[DW-1:0];
         end
         default: begin
            res_we_s = 1'b0;
         end
      endcase
      // Out-of-range accumulator writes become bubbles
      new_stage_s.valid = accept_s & acc_ok_s & (new_stage_s.hi_en | new_stage_s.lo_en);
   end

   // Pending pipeline, architectural commit and registered result
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int a = 0; a < NACC; a++) begin
            hi_r[a] <= '0;
            lo_r[a] <= '0;
         end
         for (int i = 0; i < COMMIT_LAT; i++) begin
            stage_r[i] <= '0;
         end
         out_valid_o <= 1'b0;
         out_we_o    <= 1'b0;
         out_data_o  <= '0;
      end else begin
         if (!stall_i) begin
            if (stage_r[COMMIT_LAT-1].valid) begin
               for (int a = 0; a < NACC; a++) begin
                  if (stage_r[COMMIT_LAT-1].acc == ACC_W'(a)) begin
                     if (stage_r[COMMIT_LAT-1].hi_en) hi_r[a] <= stage_r[COMMIT_LAT-1].hi;
                     if (stage_r[COMMIT_LAT-1].lo_en) lo_r[a] <= stage_r[COMMIT_LAT-1].lo;
                  end
               end
            end
            for (int i = 1; i < COMMIT_LAT; i++) begin
               stage_r[i] <= flush_i ? '0 : stage_r[i-1];
            end
            stage_r[0] <= new_stage_s;
         end else begin
            // Stalled flush kills everything but the last stage, which waits to commit
            for (int i = 0; i < COMMIT_LAT - 1; i++) begin
               stage_r[i] <= flush_i ? '0 : stage_r[i];
            end
         end
         out_valid_o <= accept_s;
         if (accept_s) begin
            out_we_o   <= res_we_s;
            out_data_o <= res_data_s;
         end else begin
            out_we_o   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_move_hilo_unit.sv
// Scoreboard bench: two instances (COMMIT_LAT=2/NACC=4 and COMMIT_LAT=1/NACC=3) share stimulus;
// expected results are queued at issue and popped by a negedge monitor.
module tb_move_hilo_unit;

   localparam logic [2:0] OP_NOP   = 3'd0;
   localparam logic [2:0] OP_MOVN  = 3'd1;
   localparam logic [2:0] OP_MOVZ  = 3'd2;
   localparam logic [2:0] OP_MFHI  = 3'd3;
   localparam logic [2:0] OP_MFLO  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;
   localparam logic [2:0] OP_WHILO = 3'd7;

   typedef struct {
      logic        we;
      logic [31:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        in_valid = 1'b0;
   logic [2:0]  op = 3'd0;
   logic [1:0]  acc = 2'd0;
   logic [31:0] d1 = 32'd0;
   logic [31:0] d2 = 32'd0;
   logic [63:0] wd = 64'd0;
   logic        stall = 1'b0;
   logic        flush = 1'b0;

   logic        a_valid, a_we, b_valid, b_we;
   logic [31:0] a_data, b_data;
   logic [63:0] a_arch, b_arch;

   exp_t q_a[$];
   exp_t q_b[$];
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   move_hilo_unit #(.DW(32), .NACC(4), .ACC_W(2), .COMMIT_LAT(2)) dut_a (
      .clk(clk), .resetn(resetn), .in_valid_i(in_valid), .op_i(op), .acc_i(acc),
      .opdata1_i(d1), .opdata2_i(d2), .hilo_wdata_i(wd), .stall_i(stall), .flush_i(flush),
      .out_valid_o(a_valid), .out_we_o(a_we), .out_data_o(a_data), .arch_hilo_o(a_arch));

   move_hilo_unit #(.DW(32), .NACC(3), .ACC_W(2), .COMMIT_LAT(1)) dut_b (
      .clk(clk), .resetn(resetn), .in_valid_i(in_valid), .op_i(op), .acc_i(acc),
      .opdata1_i(d1), .opdata2_i(d2), .hilo_wdata_i(wd), .stall_i(stall), .flush_i(flush),
      .out_valid_o(b_valid), .out_we_o(b_we), .out_data_o(b_data), .arch_hilo_o(b_arch));

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   // One cycle of stimulus; expectations are queued only for ops that will be accepted
   task automatic issue(input logic [2:0] o, input logic [1:0] ac, input logic [31:0] x1,
                        input logic [31:0] x2, input logic [63:0] w, input logic st,
                        input logic fl, input logic awe, input logic [31:0] adata,
                        input logic bwe, input logic [31:0] bdata);
      exp_t e;
      in_valid = 1'b1; op = o; acc = ac; d1 = x1; d2 = x2; wd = w; stall = st; flush = fl;
      if (!st && !fl) begin
         e.we = awe; e.data = adata; q_a.push_back(e);
         e.we = bwe; e.data = bdata; q_b.push_back(e);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0; stall = 1'b0; flush = 1'b0; op = OP_NOP;
   endtask

   task automatic idle(input int n, input logic st, input logic fl);
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b0; stall = st; flush = fl;
         @(posedge clk);
         #1;
         stall = 1'b0; flush = 1'b0;
      end
   endtask

   // Monitor: pop and compare whenever an instance presents a result
   always @(negedge clk) begin
      exp_t e;
      if (resetn) begin
         if (a_valid) begin
            if (q_a.size() == 0) begin
               check("a_unexpected_valid", 64'd1, 64'd0);
            end else begin
               e = q_a.pop_front();
               check("a_we", {63'd0, a_we}, {63'd0, e.we});
               check("a_data", {32'd0, a_data}, {32'd0, e.data});
            end
         end else begin
            check("a_we_idle", {63'd0, a_we}, 64'd0);
         end
         if (b_valid) begin
            if (q_b.size() == 0) begin
               check("b_unexpected_valid", 64'd1, 64'd0);
            end else begin
               e = q_b.pop_front();
               check("b_we", {63'd0, b_we}, {63'd0, e.we});
               check("b_data", {32'd0, b_data}, {32'd0, e.data});
            end
         end else begin
            check("b_we_idle", {63'd0, b_we}, 64'd0);
         end
      end
   end

   task automatic check_zero_outputs(input string tag);
      check({tag, "_a_valid"}, {63'd0, a_valid}, 64'd0);
      check({tag, "_a_we"}, {63'd0, a_we}, 64'd0);
      check({tag, "_a_data"}, {32'd0, a_data}, 64'd0);
      check({tag, "_a_arch"}, a_arch, 64'd0);
      check({tag, "_b_valid"}, {63'd0, b_valid}, 64'd0);
      check({tag, "_b_we"}, {63'd0, b_we}, 64'd0);
      check({tag, "_b_data"}, {32'd0, b_data}, 64'd0);
      check({tag, "_b_arch"}, b_arch, 64'd0);
   endtask

   initial begin
      #12;
      check_zero_outputs("reset");
      #10 resetn = 1'b1;
      @(posedge clk);
      #1;

      // MOVN / MOVZ / NOP
      issue(OP_MOVN, 2'd0, 32'hDEADBEEF, 32'd0, 64'd0, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF);
      issue(OP_MOVZ, 2'd0, 32'hDEADBEEF, 32'd0, 64'd0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF);
      issue(OP_MOVN, 2'd0, 32'h12345678, 32'd5, 64'd0, 1'b0, 1'b0, 1'b1, 32'h12345678, 1'b1, 32'h12345678);
      issue(OP_MOVZ, 2'd0, 32'h12345678, 32'd5, 64'd0, 1'b0, 1'b0, 1'b0, 32'h12345678, 1'b0, 32'h12345678);
      issue(OP_NOP,  2'd0, 32'h12345678, 32'd5, 64'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);

      // MTHI forwarding, independent LO, later architectural read
      issue(OP_MTHI, 2'd1, 32'h11111111, 32'd0, 64'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      issue(OP_MFHI, 2'd1, 32'd0, 32'd0, 64'd0, 1'b0, 1'b0, 1'b1, 32'h11111111, 1'b1, 32'h11111111);
      issue(OP_MFLO, 2'd1, 32'd0, 32'd0, 64'd0, 1'b0, 1'b0, 1'b1, 32'd0, 1'b1, 32'd0);
      idle(2, 1'b0, 1'b0);
      issue(OP_MFHI, 2'd1, 32'd0, 32'd0, 64'd0, 1'b0, 1'b0, 1'b1, 32'h11111111, 1'b1, 32'h11111111);

      // WHILO then MTLO: youngest wins per half, commit timing per latency
      issue(OP_WHILO, 2'd0, 32'd0, 32'd0, 64'hAAAA0000_0000BBBB, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      check("whilo_e0_a_arch", a_arch, 64'd0);
      check("whilo_e0_b_arch", b_arch, 64'd0);
      issue(OP_MTLO, 2'd0, 32'h5, 32'd0, 64'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      check("whilo_e1_a_arch", a_arch, 64'd0);
      check("whilo_e1_b_arch", b_arch, 64'hAAAA0000_0000BBBB);
      issue(OP_MFLO, 2'd0, 32'd0, 32'd0, 64'd0, 1'b0, 1'b0, 1'b1, 32'h5, 1'b1, 32'h5);
      check("whilo_e2_a_arch", a_arch, 64'hAAAA0000_0000BBBB);
      check("whilo_e2_b_arch", b_arch, 64'hAAAA0000_00000005);
      issue(OP_MFHI, 2'd0, 32'd0, 32'd0, 64'd0, 1'b0, 1'b0, 1'b1, 32'hAAAA0000, 1'b1, 32'hAAAA0000);
      check("whilo_e3_a_arch", a_arch, 64'hAAAA0000_00000005);
      check("whilo_e3_b_arch", b_arch, 64'hAAAA0000_00000005);

      // Flush after MTHI: killed at latency 2, committed at latency 1; flush beats in_valid
      issue(OP_MTHI, 2'd2, 32'h7, 32'd0, 64'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      issue(OP_MFHI, 2'd2, 32'd0, 32'd0, 64'd0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
      issue(OP_MFHI, 2'd2, 32'd0, 32'd0, 64'd0, 1'b0, 1'b0, 1'b1, 32'd0, 1'b1, 32'h7);
      idle(2, 1'b0, 1'b0);
      issue(OP_MFHI, 2'd2, 32'd0, 32'd0, 64'd0, 1'b0, 1'b0, 1'b1, 32'd0, 1'b1, 32'h7);

      // Flush during stall: younger stages die, last stage holds then commits
      issue(OP_MTHI, 2'd1, 32'h22, 32'd0, 64'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      idle(1, 1'b1, 1'b1);
      idle(1, 1'b0, 1'b0);
      issue(OP_MFHI, 2'd1, 32'd0, 32'd0, 64'd0, 1'b0, 1'b0, 1'b1, 32'h11111111, 1'b1, 32'h22);

      // Stall with write in flight; acc3 is out of range on the NACC=3 instance
      issue(OP_MTLO, 2'd3, 32'h9, 32'd0, 64'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      for (int i = 0; i < 3; i++)
         issue(OP_MFLO, 2'd3, 32'd0, 32'd0, 64'd0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      issue(OP_MFLO, 2'd3, 32'd0, 32'd0, 64'd0, 1'b0, 1'b0, 1'b1, 32'h9, 1'b1, 32'd0);

      // Stall holds commit of an acc0 write, visible on arch_hilo_o
      issue(OP_MTLO, 2'd0, 32'h77, 32'd0, 64'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      for (int i = 0; i < 3; i++) begin
         idle(1, 1'b1, 1'b0);
         check("stall_a_arch", a_arch, 64'hAAAA0000_00000005);
         check("stall_b_arch", b_arch, 64'hAAAA0000_00000005);
      end
      idle(1, 1'b0, 1'b0);
      check("unstall1_a_arch", a_arch, 64'hAAAA0000_00000005);
      check("unstall1_b_arch", b_arch, 64'hAAAA0000_00000077);
      idle(1, 1'b0, 1'b0);
      check("unstall2_a_arch", a_arch, 64'hAAAA0000_00000077);

      // Asynchronous reset with writes in flight
      issue(OP_MTHI, 2'd0, 32'h55, 32'd0, 64'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      issue(OP_MFHI, 2'd0, 32'd0, 32'd0, 64'd0, 1'b0, 1'b0, 1'b1, 32'h55, 1'b1, 32'h55);
      @(negedge clk);
      #1 resetn = 1'b0;
      #1 check_zero_outputs("midreset");
      #1 resetn = 1'b1;
      @(posedge clk);
      #1;
      issue(OP_MFHI, 2'd0, 32'd0, 32'd0, 64'd0, 1'b0, 1'b0, 1'b1, 32'd0, 1'b1, 32'd0);
      issue(OP_MFHI, 2'd1, 32'd0, 32'd0, 64'd0, 1'b0, 1'b0, 1'b1, 32'd0, 1'b1, 32'd0);
      issue(OP_MFLO, 2'd0, 32'd0, 32'd0, 64'd0, 1'b0, 1'b0, 1'b1, 32'd0, 1'b1, 32'd0);
      idle(3, 1'b0, 1'b0);
      check("post_reset_a_arch", a_arch, 64'd0);
      check("post_reset_b_arch", b_arch, 64'd0);

      check("a_queue_drained", 64'(q_a.size()), 64'd0);
      check("b_queue_drained", 64'(q_b.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/move_hilo_unit.md
Name: move_hilo_unit

Overview:
EX-stage move unit, successor to the single-pair combinational move logic. Handles MOVN/MOVZ, MFHI/MFLO and MTHI/MTLO, plus full HI/LO writes from the mul/div path, across NACC accumulator pairs. Owns the architectural HI/LO storage behind a COMMIT_LAT-deep pending-write pipeline, with youngest-first forwarding, stall and flush. Op decode from aluop to op_i is done upstream.

Parameters:
DW, 32, data/GPR width
NACC, 4, number of HI/LO accumulator pairs (≥1)
ACC_W, 2, accumulator select width, equal to max(1, clog2(NACC))
COMMIT_LAT, 2, cycles from issue to architectural HI/LO update (≥1)

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
in_valid_i  in  1  op present this cycle
op_i  in  3  0 NOP, 1 MOVN, 2 MOVZ, 3 MFHI, 4 MFLO, 5 MTHI, 6 MTLO, 7 WHILO
acc_i  in  ACC_W  accumulator select
opdata1_i  in  DW  rs value (move source)
opdata2_i  in  DW  rt value (MOVN/MOVZ condition)
hilo_wdata_i  in  2*DW  WHILO data, {HI,LO}
stall_i  in  1  freeze issue and pending pipeline
flush_i  in  1  kill issuing op and uncommitted pending writes
out_valid_o  out  1  registered result valid
out_we_o  out  1  GPR write enable (0 = unwrite)
out_data_o  out  DW  GPR write data
arch_hilo_o  out  2*DW  committed {HI,LO} of accumulator 0 (debug)

Behaviour:
- Reset (resetn=0, async): all HI/LO = 0, all pending stages invalid, out_valid_o=0, out_we_o=0, out_data_o=0.
- Accept: op accepted on a rising edge when in_valid_i=1, stall_i=0, flush_i=0. Result latency is 1 cycle.
- out_valid_o <= accepted. On non-accept edges out_valid_o <= 0, out_we_o <= 0, and out_data_o holds.
- MOVN: data = opdata1_i; we = (opdata2_i != 0).
- MOVZ: data = opdata1_i; we = (opdata2_i == 0).
- MFHI/MFLO: data = forwarded HI/LO of acc_i; we = 1.
- MTHI/MTLO: enqueue a pending write to HI or LO of acc_i with value opdata1_i; we = 0, data = 0.
- WHILO: enqueue a write to both halves, HI = hilo_wdata_i[2DW-1:DW], LO = hilo_wdata_i[DW-1:0]; we = 0.
- NOP accepted: out_valid_o = 1, we = 0, data = 0.
- Pending pipeline: stages 0..COMMIT_LAT-1. Each stage holds {valid, acc, hi_en, lo_en, hi, lo}.
  - An accepted write op enters stage 0; any other accepted op inserts a bubble.
  - Stages shift once per cycle when stall_i=0 and hold when stall_i=1.
  - A valid stage COMMIT_LAT-1 writes the enabled halves into HI/LO[acc] on the shifting edge.
- Forwarding (MFHI/MFLO): the youngest valid stage with matching acc and the relevant half enable wins; otherwise the architectural value.
  - Halves are independent: an MTHI in flight does not shadow LO.
- Flush: invalidates stages 0..COMMIT_LAT-2 and the issuing op. The last stage still commits that edge.
  - flush_i with stall_i=1: flush applies, stages do not shift, and the last stage does not commit.
  - flush_i has priority over in_valid_i.
- acc_i ≥ NACC: read returns 0 and the write is discarded (enqueued as a bubble).
- Reset mid-operation discards all pending writes.

Test Plan:
1. MOVN with opdata1=0xDEADBEEF, opdata2=0 -> out_valid_o=1, out_we_o=0, out_data_o=0xDEADBEEF. MOVZ with the same operands -> out_we_o=1.
2. MTHI acc1 0x11111111, then MFHI acc1 on the next cycle -> data 0x11111111 (forwarded). arch HI[1] updates COMMIT_LAT cycles after issue. MFLO acc1 -> 0.
3. WHILO acc0 {0xAAAA0000,0x0000BBBB}, then MTLO acc0 0x5, then MFLO/MFHI acc0 -> 0x5 / 0xAAAA0000 (youngest wins per half). arch_hilo_o settles to {0xAAAA0000,0x5}.
4. MTHI acc2 0x7 followed by flush_i the next cycle (COMMIT_LAT=2) -> pending write killed, MFHI acc2 returns 0. Repeat at COMMIT_LAT=1 -> write commits despite flush.
5. MTLO acc3 0x9 then stall_i=1 for 3 cycles -> out_valid_o=0 during stall, arch LO[3] unchanged until 2 unstalled cycles elapse, MFLO acc3 forwards 0x9 throughout.
6. resetn pulsed low with writes in flight -> all outputs 0 immediately, HI/LO of every accumulator read 0 afterwards.
